// File: rtl/mem_bist_ctrl.sv
// March-style memory self-test initiator: write pattern, read/compare, write inverse,
// read/compare, then report error count and the first failing address/data.
module mem_bist_ctrl #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 128,
    parameter int ADD_WIDTH = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [WIDTH-1:0]       seed,
    output logic [ADD_WIDTH-1:0]   addr,
    output logic [WIDTH-1:0]       wdata,
    output logic                   wr_en,
    output logic                   rd_en,
    input  logic [WIDTH-1:0]       rdata,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [ADD_WIDTH+1:0]   err_count,
    output logic [ADD_WIDTH-1:0]   fail_addr,
    output logic [WIDTH-1:0]       fail_data
);

    typedef enum logic [2:0] {IDLE, WR0, RD0, WR1, RD1, FLUSH, DONE} state_t;

    localparam logic [ADD_WIDTH-1:0] LAST_ADDR = ADD_WIDTH'(DEPTH - 1);
    localparam logic [ADD_WIDTH-1:0] ADDR_ONE  = ADD_WIDTH'(1);
    localparam logic [ADD_WIDTH+1:0] ERR_ONE   = (ADD_WIDTH + 2)'(1);

    state_t                 state, state_next;
    logic [ADD_WIDTH-1:0]   addr_next;
    logic [WIDTH-1:0]       seed_q, seed_next;
    logic [WIDTH-1:0]       wdata_next;
    logic                   accept;
    logic                   chk_vld;
    logic [ADD_WIDTH-1:0]   chk_addr;
    logic [WIDTH-1:0]       chk_exp;
    logic                   mismatch;
    logic [ADD_WIDTH+1:0]   err_next;

    function automatic logic [WIDTH-1:0] pat(input logic [WIDTH-1:0] s,
                                              input logic [ADD_WIDTH-1:0] a);
        return s ^ WIDTH'(a);
    endfunction

    assign accept = start && (state == IDLE || state == DONE);

    // Address counter restarts at 0 on every phase change and stops at DEPTH-1.
    always_comb begin
        state_next = state;
        addr_next  = addr;
        seed_next  = seed_q;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = WR0;
                    addr_next  = '0;
                    seed_next  = seed;
                end
            end
            WR0, RD0, WR1, RD1: begin
                if (addr == LAST_ADDR) begin
                    addr_next = '0;
                    case (state)
                        WR0:     state_next = RD0;
                        RD0:     state_next = WR1;
                        WR1:     state_next = RD1;
                        default: state_next = FLUSH;
                    endcase
                end else begin
                    addr_next = addr + ADDR_ONE;
                end
            end
            FLUSH: begin
                state_next = DONE;
                addr_next  = '0;
            end
            default: begin
                state_next = IDLE;
                addr_next  = '0;
            end
        endcase

        wdata_next = '0;
        if (state_next == WR0)
            wdata_next = pat(seed_next, addr_next);
        else if (state_next == WR1)
            wdata_next = ~pat(seed_next, addr_next);
    end

    assign mismatch = chk_vld && (rdata != chk_exp);

    always_comb begin
        err_next = err_count;
        if (accept)
            err_next = '0;
        else if (mismatch && err_count != '1)
            err_next = err_count + ERR_ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            seed_q <= '0;
            addr   <= '0;
            wdata  <= '0;
            wr_en  <= 1'b0;
            rd_en  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            pass   <= 1'b0;
        end else begin
            state  <= state_next;
            seed_q <= seed_next;
            addr   <= addr_next;
            wdata  <= wdata_next;
            wr_en  <= (state_next == WR0) || (state_next == WR1);
            rd_en  <= (state_next == RD0) || (state_next == RD1);
            busy   <= (state_next != IDLE) && (state_next != DONE);
            done   <= (state_next == DONE);
            pass   <= (state_next == DONE) && (err_next == '0);
        end
    end

    // Compare stage trails the read request by one cycle to cover the memory's read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_vld   <= 1'b0;
            chk_addr  <= '0;
            chk_exp   <= '0;
            err_count <= '0;
            fail_addr <= '0;
            fail_data <= '0;
        end else begin
            chk_vld   <= rd_en;
            chk_addr  <= addr;
            chk_exp   <= (state == RD1) ? ~pat(seed_q, addr) : pat(seed_q, addr);
            err_count <= err_next;
            if (accept) begin
                fail_addr <= '0;
                fail_data <= '0;
            end else if (mismatch && err_count == '0) begin
                fail_addr <= chk_addr;
                fail_data <= rdata;
            end
        end
    end

endmodule
